// File: rtl/multicycle_chunk_adder_pkg.sv
// Shared types for the multicycle chunk adder: FSM encoding, operation mode
// and the slice-index width helper.
package multicycle_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_t;

  // Index counter width; a single-slice build still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicycle_chunk_adder_nbit_adder.sv
// Combinational N-bit ripple adder built from full adders; also exposes the
// carry into the top bit for signed-overflow detection.
module nbit_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [N:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout  = w_c[N];
  assign c_msb = w_c[N-1];

endmodule

// File: rtl/multicycle_chunk_adder.sv
// Low-area add/sub unit: processes one CHUNK-bit slice per cycle, LSB first,
// with the inter-slice carry held in a register; valid/ready on both sides.
module multicycle_chunk_adder
  import multicycle_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;
  logic [IDXW-1:0]  r_idx;

  logic [31:0]      w_shift;
  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic             w_slice_cmsb;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

  // Current slice selection and merge of the new slice into the sum.
  always_comb begin
    w_shift    = 32'(r_idx) * 32'(CHUNK);
    w_a_slice  = CHUNK'(r_a >> w_shift);
    w_b_slice  = CHUNK'(r_b >> w_shift);
    w_sum_next = (r_sum & ~(WIDTH'({CHUNK{1'b1}}) << w_shift))
               | (WIDTH'(w_slice_sum) << w_shift);
    w_last     = (r_idx == LAST_IDX);
  end

  nbit_adder #(.N(CHUNK)) u_slice_adder (
    .a     (w_a_slice),
    .b     (w_b_slice),
    .cin   (r_carry),
    .sum   (w_slice_sum),
    .cout  (w_slice_cout),
    .c_msb (w_slice_cmsb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)     w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (out_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Status flags track the state being entered so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_next == ST_IDLE);
      r_busy      <= (w_state_next == ST_RUN);
      r_out_valid <= (w_state_next == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= (mode_t'(sub) == MODE_SUB) ? 1'b1 : carry_in;
            r_sum   <= '0;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_slice_cout;
          if (w_last) begin
            r_idx       <= '0;
            r_carry_out <= w_slice_cout;
            r_overflow  <= w_slice_cmsb ^ w_slice_cout;
            r_zero      <= (w_sum_next == '0);
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule
